// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: machine word, RAM handshake state and arbiter FSM state.
package cpu_types_pkg;

    localparam int WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        IGNT = 2'd1,
        DGNT = 2'd2
    } arb_state_t;

endpackage

// File: rtl/memory_arbiter_if.sv
// Bundle of instruction-port, data-port and RAM-side signals around the memory arbiter.
interface memory_arbiter_if;
    import cpu_types_pkg::*;

    logic      iREN;
    word_t     iaddr;
    logic      ihit;
    word_t     iload;

    logic      dREN;
    logic      dWEN;
    word_t     daddr;
    word_t     dstore;
    logic      dhit;
    word_t     dload;

    logic      ramREN;
    logic      ramWEN;
    word_t     ramaddr;
    word_t     ramstore;
    word_t     ramload;
    ramstate_t ramstate;

    logic      err;

    // Arbiter side
    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output ihit, iload, dhit, dload, ramREN, ramWEN, ramaddr, ramstore, err
    );

    // CPU/RAM environment side
    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        input  ihit, iload, dhit, dload, ramREN, ramWEN, ramaddr, ramstore, err
    );

endinterface

// File: rtl/memory_arbiter.sv
// Single-port RAM arbiter between instruction fetch and data access, with
// anti-starvation for instruction fetch, RAM error/timeout detection and a sticky error flag.
module memory_arbiter
    import cpu_types_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 255
) (
    input  logic              CLK,
    input  logic              RST,
    memory_arbiter_if.slave   bus
);

    localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam int WW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
    localparam logic [WW-1:0] WAIT_LAST  = WW'(TIMEOUT - 1);

    arb_state_t     state_reg, state_next;
    word_t          addr_reg, addr_next;
    word_t          store_reg, store_next;
    logic           wr_reg, wr_next;
    logic [SW-1:0]  starve_cnt_reg, starve_cnt_next;
    logic [WW-1:0]  wait_cnt_reg, wait_cnt_next;
    logic           err_reg, err_next;

    logic           d_req;
    logic           i_wins;
    logic           owner_en;

    always_comb begin
        d_req    = bus.dREN | bus.dWEN;
        // Instruction only overrides a pending data request once it has been starved long enough
        i_wins   = bus.iREN & (~d_req | (starve_cnt_reg == STARVE_MAX));
        owner_en = (state_reg == IGNT) ? bus.iREN : d_req;
    end

    always_comb begin
        state_next      = state_reg;
        addr_next       = addr_reg;
        store_next      = store_reg;
        wr_next         = wr_reg;
        starve_cnt_next = starve_cnt_reg;
        wait_cnt_next   = wait_cnt_reg;
        err_next        = err_reg;

        bus.ihit        = 1'b0;
        bus.iload       = '0;
        bus.dhit        = 1'b0;
        bus.dload       = '0;
        bus.ramREN      = 1'b0;
        bus.ramWEN      = 1'b0;
        bus.ramaddr     = '0;
        bus.ramstore    = '0;

        case (state_reg)
            IDLE: begin
                if (bus.iREN | d_req) begin
                    wait_cnt_next = '0;
                    if (i_wins) begin
                        state_next      = IGNT;
                        addr_next       = bus.iaddr;
                        store_next      = '0;
                        wr_next         = 1'b0;
                        starve_cnt_next = '0;
                    end else begin
                        state_next = DGNT;
                        addr_next  = bus.daddr;
                        store_next = bus.dstore;
                        // A simultaneous read and write request is a write
                        wr_next    = bus.dWEN;
                        if (bus.iREN && (starve_cnt_reg != STARVE_MAX)) begin
                            starve_cnt_next = starve_cnt_reg + 1'b1;
                        end
                    end
                end
            end

            IGNT, DGNT: begin
                bus.ramREN   = ~wr_reg;
                bus.ramWEN   = wr_reg;
                bus.ramaddr  = addr_reg;
                bus.ramstore = store_reg;

                if (bus.ramstate == ACCESS) begin
                    state_next = IDLE;
                    // An abandoned access still finishes at the RAM, but nobody is told
                    if (owner_en) begin
                        if (state_reg == IGNT) begin
                            bus.ihit  = 1'b1;
                            bus.iload = bus.ramload;
                        end else begin
                            bus.dhit  = 1'b1;
                            bus.dload = wr_reg ? '0 : bus.ramload;
                        end
                    end
                end else if (bus.ramstate == ERROR) begin
                    err_next   = 1'b1;
                    state_next = IDLE;
                end else if (wait_cnt_reg == WAIT_LAST) begin
                    err_next   = 1'b1;
                    state_next = IDLE;
                end else begin
                    wait_cnt_next = wait_cnt_reg + 1'b1;
                end
            end

            default: state_next = IDLE;
        endcase

        // Error is visible in the very cycle it is detected, then held by err_reg
        bus.err = err_next;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg      <= IDLE;
            addr_reg       <= '0;
            store_reg      <= '0;
            wr_reg         <= 1'b0;
            starve_cnt_reg <= '0;
            wait_cnt_reg   <= '0;
            err_reg        <= 1'b0;
        end else begin
            state_reg      <= state_next;
            addr_reg       <= addr_next;
            store_reg      <= store_next;
            wr_reg         <= wr_next;
            starve_cnt_reg <= starve_cnt_next;
            wait_cnt_reg   <= wait_cnt_next;
            err_reg        <= err_next;
        end
    end

endmodule

// File: tb/tb_memory_arbiter.sv
// Self-checking bench for memory_arbiter: directed scenarios plus randomized
// transactions predicted by a transaction-level priority/starvation model.
module tb_memory_arbiter;
    import cpu_types_pkg::*;

    localparam int STARVE_LIMIT = 4;
    localparam int TIMEOUT      = 255;

    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    memory_arbiter_if bus();

    memory_arbiter #(
        .STARVE_LIMIT (STARVE_LIMIT),
        .TIMEOUT      (TIMEOUT)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    int starve = 0;   // model: data wins over a waiting fetch since the last fetch grant

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic sample();
        @(negedge CLK);
    endtask

    task automatic drive_idle();
        bus.iREN     = 1'b0;
        bus.iaddr    = '0;
        bus.dREN     = 1'b0;
        bus.dWEN     = 1'b0;
        bus.daddr    = '0;
        bus.dstore   = '0;
        bus.ramload  = '0;
        bus.ramstate = FREE;
    endtask

    task automatic chk_quiet(input string tag, input logic err_exp);
        chk({tag, "_ctl"}, {59'd0, bus.ihit, bus.dhit, bus.ramREN, bus.ramWEN, bus.err},
            {59'd0, 4'b0000, err_exp});
        chk({tag, "_data"}, {bus.iload | bus.dload, bus.ramaddr | bus.ramstore}, 64'd0);
    endtask

    task automatic chk_grant(input string tag, input bit inst, input bit wr, input word_t addr,
                             input word_t store, input logic err_exp);
        chk({tag, "_strb"}, {61'd0, bus.ramREN, bus.ramWEN, bus.err}, {61'd0, ~wr, wr, err_exp});
        chk({tag, "_addr"}, {32'd0, bus.ramaddr}, {32'd0, addr});
        if (!inst) chk({tag, "_store"}, {32'd0, bus.ramstore}, {32'd0, store});
    endtask

    // One arbitration round starting in IDLE. dop: 0 none, 1 read, 2 write, 3 read+write.
    task automatic run_txn(input string tag, input bit ir, input int dop, input word_t ia,
                           input word_t da, input word_t ds, input int lat,
                           input bit abandon, input bit resp_err);
        bit    inst_win;
        bit    wr;
        bit    last;
        bit    hit_exp;
        word_t addr;
        word_t ld;

        next_cycle();
        bus.iREN     = ir;
        bus.iaddr    = ia;
        bus.dREN     = (dop == 1) || (dop == 3);
        bus.dWEN     = (dop >= 2);
        bus.daddr    = da;
        bus.dstore   = ds;
        bus.ramstate = ($urandom_range(0, 1) != 0) ? ACCESS : FREE;
        bus.ramload  = $urandom;
        sample();
        chk_quiet({tag, "_idle"}, 1'b0);
        if (!ir && dop == 0) return;

        inst_win = ir && (dop == 0 || starve == STARVE_LIMIT);
        wr       = !inst_win && (dop >= 2);
        addr     = inst_win ? ia : da;
        if (inst_win) starve = 0;
        else if (ir && starve < STARVE_LIMIT) starve++;

        for (int j = 0; j <= lat; j++) begin
            next_cycle();
            if (abandon && j == 0) begin
                if (inst_win) bus.iREN = 1'b0;
                else begin
                    bus.dREN = 1'b0;
                    bus.dWEN = 1'b0;
                end
            end
            last         = (j == lat);
            bus.ramstate = !last ? BUSY : (resp_err ? ERROR : ACCESS);
            ld           = $urandom;
            bus.ramload  = ld;
            sample();
            chk_grant({tag, "_gnt"}, inst_win, wr, addr, ds, last && resp_err);
            hit_exp = last && !resp_err && !abandon;
            chk({tag, "_hit"}, {62'd0, bus.ihit, bus.dhit},
                {62'd0, inst_win && hit_exp, !inst_win && hit_exp});
            chk({tag, "_load"}, {bus.iload, bus.dload},
                {(inst_win && hit_exp) ? ld : 32'd0, (!inst_win && hit_exp && !wr) ? ld : 32'd0});
        end

        if (resp_err) begin
            next_cycle();
            drive_idle();
            sample();
            chk_quiet({tag, "_errhold"}, 1'b1);
            RST = 1'b1;
            next_cycle();
            RST = 1'b0;
            sample();
            chk_quiet({tag, "_errrst"}, 1'b0);
            starve = 0;
        end
    endtask

    initial begin
        RST = 1'b1;
        drive_idle();
        next_cycle();
        next_cycle();
        RST = 1'b0;
        sample();
        chk_quiet("reset", 1'b0);

        // Fetch with two BUSY cycles before ACCESS
        run_txn("fetch_lat2", 1'b1, 0, 32'h40, 32'h0, 32'h0, 2, 1'b0, 1'b0);
        // Fetch and write together: data first, then the fetch
        run_txn("both_data", 1'b1, 2, 32'h80, 32'h100, 32'hDEADBEEF, 0, 1'b0, 1'b0);
        run_txn("both_inst", 1'b1, 0, 32'h80, 32'h0, 32'h0, 0, 1'b0, 1'b0);
        // Read and write both asserted behaves as a write
        run_txn("rw_write", 1'b0, 3, 32'h0, 32'h140, 32'h0BADF00D, 1, 1'b0, 1'b0);
        // Abandoned fetch and abandoned read
        run_txn("abandon_i", 1'b1, 0, 32'h44, 32'h0, 32'h0, 2, 1'b1, 1'b0);
        run_txn("abandon_d", 1'b0, 1, 32'h0, 32'h180, 32'h0, 1, 1'b1, 1'b0);

        // Starvation: fetch held, data re-requested immediately after every hit
        for (int k = 0; k < 12; k++) begin
            run_txn("starve", 1'b1, 1, 32'h48, 32'h200 + k * 4, 32'h0, 0, 1'b0, 1'b0);
        end

        // Randomized rounds, including RAM ERROR responses
        for (int k = 0; k < 150; k++) begin
            run_txn("rand", 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), $urandom,
                    $urandom, $urandom, int'($urandom_range(0, 3)),
                    $urandom_range(0, 4) == 0, $urandom_range(0, 11) == 0);
        end

        // Timeout: RAM never leaves BUSY
        next_cycle();
        drive_idle();
        bus.dREN     = 1'b1;
        bus.daddr    = 32'h300;
        bus.ramstate = BUSY;
        sample();
        chk_quiet("to_req", 1'b0);
        for (int g = 1; g <= TIMEOUT; g++) begin
            next_cycle();
            sample();
            chk("to_wait", {61'd0, bus.ramREN, bus.dhit, bus.err},
                {61'd0, 1'b1, 1'b0, g == TIMEOUT});
        end
        next_cycle();
        bus.dREN = 1'b0;
        sample();
        chk_quiet("to_idle", 1'b1);
        for (int k = 0; k < 3; k++) begin
            next_cycle();
            bus.ramstate = ACCESS;
            sample();
            chk_quiet("to_sticky", 1'b1);
        end

        // Reset during a data grant with the RAM still BUSY
        next_cycle();
        bus.dREN     = 1'b1;
        bus.daddr    = 32'h400;
        bus.ramstate = BUSY;
        sample();
        chk_quiet("rst_req", 1'b1);
        next_cycle();
        sample();
        chk_grant("rst_gnt", 1'b0, 1'b0, 32'h400, 32'h0, 1'b1);
        RST = 1'b1;
        next_cycle();
        RST      = 1'b0;
        bus.dREN = 1'b0;
        sample();
        chk_quiet("rst_abort", 1'b0);
        for (int k = 0; k < 3; k++) begin
            next_cycle();
            bus.ramstate = ACCESS;
            sample();
            chk_quiet("rst_nohit", 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
